// File: rtl/uart_rx_engine_if.sv
// Receive-side consumer handshake for uart_rx_engine.
// master: engine drives byte/flags and reads rx_ack; slave: consumer side.
interface uart_rx_engine_if;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_ack;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       rx_busy;

    modport master (
        output rx_data,
        output rx_avail,
        output rx_overrun,
        output rx_frame_err,
        output rx_busy,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_avail,
        input  rx_overrun,
        input  rx_frame_err,
        input  rx_busy,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx_engine.sv
// 8N1 UART receiver, 16x oversampled, level-valid/ack byte delivery.
// Ports: clk, rst (sync, active-high), uart_rxd (async line), rx_if (master).
module uart_rx_engine #(
    parameter int clk_freq       = 100000000,
    parameter int uart_baud_rate = 115200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rxd,
    uart_rx_engine_if.master  rx_if
);
    localparam int DIV = clk_freq / (uart_baud_rate * 16);
    localparam int TW  = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_div_chk
        $error("uart_rx_engine: tick divisor must be >= 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]      smp_cnt_q, smp_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            avail_q, avail_d;
    logic            ovr_q, ovr_d;
    logic            ferr_q, ferr_d;
    logic            busy_q, busy_d;
    logic            rxs;
    logic            tick;
    logic            deliver;

    assign rxs = sync2_q;

    always_comb begin
        state_d    = state_q;
        sync1_d    = uart_rxd;
        sync2_d    = sync1_q;
        smp_cnt_d  = smp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        avail_d    = avail_q;
        ovr_d      = ovr_q;
        ferr_d     = 1'b0;
        deliver    = 1'b0;

        tick       = (tick_cnt_q == TW'(DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    // restart the tick phase on the start edge
                    state_d    = START;
                    smp_cnt_d  = '0;
                    tick_cnt_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (smp_cnt_q == 4'd7) begin
                        if (rxs) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            smp_cnt_d = '0;
                            bit_cnt_d = '0;
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    // 4-bit counter wraps 15 -> 0 at each bit centre
                    smp_cnt_d = smp_cnt_q + 4'd1;
                    if (smp_cnt_q == 4'd15) begin
                        shift_d[bit_cnt_q] = rxs;
                        bit_cnt_d          = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    smp_cnt_d = smp_cnt_q + 4'd1;
                    if (smp_cnt_q == 4'd15) begin
                        if (rxs) begin
                            deliver = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_IDLE;
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                // a held-low line (break) must not look like a new start
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rx_if.rx_ack && avail_q) begin
            avail_d = 1'b0;
            ovr_d   = 1'b0;
        end

        // an ack in the delivery cycle frees the slot for the new byte
        if (deliver) begin
            if (avail_q && !rx_if.rx_ack) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                avail_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            tick_cnt_q <= '0;
            smp_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            avail_q    <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            tick_cnt_q <= tick_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            avail_q    <= avail_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_if.rx_data      = data_q;
    assign rx_if.rx_avail     = avail_q;
    assign rx_if.rx_overrun   = ovr_q;
    assign rx_if.rx_frame_err = ferr_q;
    assign rx_if.rx_busy      = busy_q;
endmodule
